// File: rtl/ctrl_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths,
// the buffered {pc, instr} entry layout and sizing helpers.
package ctrl_fetch_pkg;

    localparam int unsigned PROG_CTR_WID_DEF = 10;
    localparam int unsigned INSTR_WID_DEF    = 16;

    typedef struct packed {
        logic [PROG_CTR_WID_DEF-1:0] pc;
        logic [INSTR_WID_DEF-1:0]    instr;
    } fetch_entry_t;

    // Width needed to hold an occupancy count of 0..depth.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ctrl_fetch_fifo.sv
// Small instruction buffer with push/pop/flush; pointers wrap modulo DEPTH.
// Flush empties the buffer in one edge and overrides any push or pop.
module ctrl_fetch_fifo
    import ctrl_fetch_pkg::*;
#(
    parameter  int unsigned DEPTH  = 2,
    parameter  int unsigned DATA_W = 26,
    localparam int unsigned CNT_W  = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int unsigned      PTR_W    = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    no_push_into_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/ctrl_instr_fetch.sv
// Instruction-fetch stage: issues one imem read per cycle when the buffer
// has room, buffers {pc, instr} responses and hands them to decode.
module ctrl_instr_fetch
    import ctrl_fetch_pkg::*;
#(
    parameter int unsigned PROG_CTR_WID = PROG_CTR_WID_DEF,
    parameter int unsigned INSTR_WID    = INSTR_WID_DEF,
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PROG_CTR_WID-1:0] prog_ctr,
    input  logic                    branch_taken_EX,
    output logic [PROG_CTR_WID-1:0] imem_addr,
    output logic                    imem_rd_en,
    input  logic [INSTR_WID-1:0]    imem_rdata,
    output logic                    stall_IF,
    output logic                    instr_valid_ID,
    input  logic                    instr_ready_ID,
    output logic [INSTR_WID-1:0]    instr_ID,
    output logic [PROG_CTR_WID-1:0] pc_ID
);

    localparam int unsigned      CNT_W     = cnt_width(FIFO_DEPTH);
    localparam int unsigned      OCC_W     = CNT_W + 1;
    localparam int unsigned      ENTRY_W   = PROG_CTR_WID + INSTR_WID;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);

    logic                    inflight_q, inflight_d;
    logic [PROG_CTR_WID-1:0] inflight_pc_q, inflight_pc_d;

    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic               push, pop, flush, issue;
    logic [OCC_W-1:0]   occupancy;

    assign flush = branch_taken_EX;
    assign pop   = instr_valid_ID & instr_ready_ID;
    assign push  = inflight_q & ~flush;

    // Credit check: buffered entries plus the outstanding read must leave a
    // free slot, unless decode frees one this very cycle.
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_q);
    assign issue     = reset & ~branch_taken_EX & ((occupancy < DEPTH_OCC) | pop);

    assign imem_addr  = prog_ctr;
    assign imem_rd_en = issue;
    assign stall_IF   = reset & ~issue & ~branch_taken_EX;

    assign instr_valid_ID    = ~fifo_empty;
    assign {pc_ID, instr_ID} = fifo_head;

    always_comb begin
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (issue) begin
            inflight_pc_d = prog_ctr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    ctrl_fetch_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .push_data ({inflight_pc_q, imem_rdata}),
        .pop       (pop),
        .flush     (flush),
        .head_data (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    response_has_room: assert property (@(posedge clk) disable iff (!reset) !(push && fifo_full));

endmodule

// File: tb/tb_ctrl_instr_fetch.sv
// Table-driven bench for ctrl_instr_fetch with a PC model and a synchronous
// instruction memory holding 0xA000 + address.
module tb_ctrl_instr_fetch;

    localparam int unsigned PW = 10;
    localparam int unsigned IW = 16;

    logic          clk;
    logic          reset;
    logic [PW-1:0] prog_ctr;
    logic          branch_taken_EX;
    logic [PW-1:0] imem_addr;
    logic          imem_rd_en;
    logic [IW-1:0] imem_rdata;
    logic          stall_IF;
    logic          instr_valid_ID;
    logic          instr_ready_ID;
    logic [IW-1:0] instr_ID;
    logic [PW-1:0] pc_ID;

    logic [PW-1:0] pc_q;
    logic [PW-1:0] pc_idle;
    logic [PW-1:0] tgt;

    int passed;
    int total;

    ctrl_instr_fetch #(
        .PROG_CTR_WID (PW),
        .INSTR_WID    (IW),
        .FIFO_DEPTH   (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .prog_ctr        (prog_ctr),
        .branch_taken_EX (branch_taken_EX),
        .imem_addr       (imem_addr),
        .imem_rd_en      (imem_rd_en),
        .imem_rdata      (imem_rdata),
        .stall_IF        (stall_IF),
        .instr_valid_ID  (instr_valid_ID),
        .instr_ready_ID  (instr_ready_ID),
        .instr_ID        (instr_ID),
        .pc_ID           (pc_ID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter: holds on stall, loads the target on a branch.
    always @(posedge clk or negedge reset) begin
        if (!reset)               pc_q <= '0;
        else if (branch_taken_EX) pc_q <= tgt;
        else if (!stall_IF)       pc_q <= pc_q + 1'b1;
    end
    assign prog_ctr = reset ? pc_q : pc_idle;

    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= 16'hA000 + IW'(imem_addr);
    end

    typedef struct {
        logic          rst;
        logic          rdy;
        logic          br;
        logic [PW-1:0] tgt;
        logic          exp_valid;
        logic [PW-1:0] exp_pc;
        logic          exp_stall;
        logic          exp_rden;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic rdy, input logic br,
                                input logic [PW-1:0] t, input logic v,
                                input logic [PW-1:0] pc, input logic st, input logic rd);
        vec_t e;
        e.rst = rst; e.rdy = rdy; e.br = br; e.tgt = t;
        e.exp_valid = v; e.exp_pc = pc; e.exp_stall = st; e.exp_rden = rd;
        vecs.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    initial begin
        int n;
        vec_t v;
        reset = 1'b0; instr_ready_ID = 1'b1; branch_taken_EX = 1'b0;
        tgt = '0; pc_idle = 10'h3; imem_rdata = '0;
        passed = 0; total = 0;

        // Reset, release, stream 0..9, branch to 0x40 while popping pc 9.
        for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) add(1, 1, 0, 0, 1, PW'(i), 0, 1);
        add(1, 1, 1, 10'h40, 1, 10'd9, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 1, 10'h40, 0, 1);
        add(1, 1, 0, 0, 1, 10'h41, 0, 1);
        // Back-pressure from pc 4, then drain 4..7.
        add(0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) add(1, 1, 0, 0, 1, PW'(i), 0, 1);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 1, 10'd4, 1, 0);
        for (int i = 4; i < 8; i++) add(1, 1, 0, 0, 1, PW'(i), 0, 1);
        // Full buffer (4,5) flushed by a branch to 0x20.
        add(0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) add(1, 1, 0, 0, 1, PW'(i), 0, 1);
        for (int i = 0; i < 2; i++) add(1, 0, 0, 0, 1, 10'd4, 1, 0);
        add(1, 0, 1, 10'h20, 1, 10'd4, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 1, 10'h20, 0, 1);
        add(1, 1, 0, 0, 1, 10'h21, 0, 1);

        foreach (vecs[i]) begin
            v = vecs[i];
            @(posedge clk);
            #1;
            reset = v.rst; instr_ready_ID = v.rdy; branch_taken_EX = v.br; tgt = v.tgt;
            #3;
            chk($sformatf("v%0d valid", i), 32'(instr_valid_ID), 32'(v.exp_valid));
            chk($sformatf("v%0d stall", i), 32'(stall_IF), 32'(v.exp_stall));
            chk($sformatf("v%0d rd_en", i), 32'(imem_rd_en), 32'(v.exp_rden));
            chk($sformatf("v%0d addr", i), 32'(imem_addr), 32'(prog_ctr));
            if (!v.rst) begin
                chk($sformatf("v%0d reset pc_ID", i), 32'(pc_ID), 32'h0);
                chk($sformatf("v%0d reset instr", i), 32'(instr_ID), 32'h0);
            end else if (v.exp_valid) begin
                chk($sformatf("v%0d pc_ID", i), 32'(pc_ID), 32'(v.exp_pc));
                chk($sformatf("v%0d instr", i), 32'(instr_ID), 32'h0000A000 + 32'(v.exp_pc));
            end
        end
        branch_taken_EX = 1'b0;

        // Asynchronous reset with one entry buffered and one read in flight.
        @(posedge clk);
        #2;
        chk("pre-reset valid", 32'(instr_valid_ID), 32'h1);
        chk("pre-reset pc_ID", 32'(pc_ID), 32'h22);
        reset = 1'b0;
        #1;
        chk("async valid", 32'(instr_valid_ID), 32'h0);
        chk("async pc_ID", 32'(pc_ID), 32'h0);
        chk("async instr", 32'(instr_ID), 32'h0);
        chk("async rd_en", 32'(imem_rd_en), 32'h0);
        chk("async stall", 32'(stall_IF), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #3;
        chk("restart no stale", 32'(instr_valid_ID), 32'h0);
        chk("restart addr", 32'(imem_addr), 32'h0);
        n = 0;
        while (!instr_valid_ID && n < 8) begin
            @(posedge clk);
            #4;
            n++;
        end
        chk("restart latency", 32'(n), 32'd2);
        chk("restart pc_ID", 32'(pc_ID), 32'h0);
        chk("restart instr", 32'(instr_ID), 32'hA000);
        @(posedge clk);
        #4;
        chk("restart next pc_ID", 32'(pc_ID), 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
